cpu_sequencer: RTL and testbench

Multi-cycle fetch/decode/execute sequencer for the full CPU system. It fetches 8-bit instructions from instruction memory through a req/ack handshake and decodes the 4-bit opcode. It issues single-cycle register load strobes and the operand to the datapath. It owns the program counter and handles JMP and HALT.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/cpu_sequencer.sv | 122 ++++++++++++
 tb/tb_cpu_sequencer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU: opcode values, instruction field widths and
// the sequencer state encoding.
package cpu_pkg;

   localparam int OPC_W = 4;
   localparam int OPD_W = 4;

   localparam logic [OPC_W-1:0] OP_NOP     = 4'h0;
   localparam logic [OPC_W-1:0] OP_LOADA   = 4'h1;
   localparam logic [OPC_W-1:0] OP_LOADB   = 4'h2;
   localparam logic [OPC_W-1:0] OP_READOUT = 4'h3;
   localparam logic [OPC_W-1:0] OP_JMP     = 4'h4;
   localparam logic [OPC_W-1:0] OP_HALT    = 4'hF;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      HALTED = 3'd4
   } state_t;

endpackage

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute sequencer: fetches instructions over a req/ack handshake,
// issues one-cycle load strobes to the datapath, and owns the program counter.
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [7:0]        imem_data,
   output logic [OPD_W-1:0]  operand,
   output logic              load_reg_a,
   output logic              load_reg_b,
   output logic              load_reg_c,
   output logic              busy,
   output logic              halted,
   output logic              illegal_op,
   output state_t            dbg_state
);

   // Handshake: imem_req stays high from FETCH entry until the cycle imem_ack is
   // seen; imem_data is captured on that edge and imem_addr is frozen meanwhile.
   state_t                   state;
   logic [ADDR_W-1:0]        pc;
   logic [OPC_W+OPD_W-1:0]   ir;
   logic                     start_armed;

   logic dec_a, dec_b, dec_c, dec_ill, dec_jmp, dec_halt;

   always_comb begin
      dec_a    = 1'b0;
      dec_b    = 1'b0;
      dec_c    = 1'b0;
      dec_ill  = 1'b0;
      dec_jmp  = 1'b0;
      dec_halt = 1'b0;
      case (ir[OPC_W+OPD_W-1:OPD_W])
         OP_NOP:     ;
         OP_LOADA:   dec_a    = 1'b1;
         OP_LOADB:   dec_b    = 1'b1;
         OP_READOUT: dec_c    = 1'b1;
         OP_JMP:     dec_jmp  = 1'b1;
         OP_HALT:    dec_halt = 1'b1;
         default:    dec_ill  = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         pc          <= '0;
         ir          <= '0;
         imem_req    <= 1'b0;
         load_reg_a  <= 1'b0;
         load_reg_b  <= 1'b0;
         load_reg_c  <= 1'b0;
         illegal_op  <= 1'b0;
         busy        <= 1'b0;
         halted      <= 1'b0;
         start_armed <= 1'b1;
      end else begin
         load_reg_a <= 1'b0;
         load_reg_b <= 1'b0;
         load_reg_c <= 1'b0;
         illegal_op <= 1'b0;
         // A start level only counts once; it must be seen low to re-arm.
         if (!start) start_armed <= 1'b1;
         case (state)
            IDLE, HALTED: begin
               if (start && start_armed) begin
                  state       <= FETCH;
                  pc          <= '0;
                  imem_req    <= 1'b1;
                  busy        <= 1'b1;
                  halted      <= 1'b0;
                  start_armed <= 1'b0;
               end
            end
            FETCH: begin
               if (imem_ack) begin
                  ir       <= imem_data;
                  imem_req <= 1'b0;
                  state    <= DECODE;
               end
            end
            DECODE: begin
               load_reg_a <= dec_a;
               load_reg_b <= dec_b;
               load_reg_c <= dec_c;
               illegal_op <= dec_ill;
               state      <= EXEC;
            end
            EXEC: begin
               if (dec_halt) begin
                  state  <= HALTED;
                  busy   <= 1'b0;
                  halted <= 1'b1;
               end else begin
                  state    <= FETCH;
                  imem_req <= 1'b1;
                  pc       <= dec_jmp ? ADDR_W'(ir[OPD_W-1:0]) : pc + ADDR_W'(1);
               end
            end
            default: begin
               state    <= IDLE;
               imem_req <= 1'b0;
               busy     <= 1'b0;
               halted   <= 1'b0;
            end
         endcase
      end
   end

   assign imem_addr = pc;
   assign operand   = ir[OPD_W-1:0];
   assign dbg_state = state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: behavioural instruction memory with
// programmable wait states, strobe logging and immediate-assert checks.
module tb_cpu_sequencer;
   import cpu_pkg::*;

   logic       clk;
   logic       rst;
   logic       start;
   logic       imem_req;
   logic [3:0] imem_addr;
   logic       imem_ack;
   logic [7:0] imem_data;
   logic [3:0] operand;
   logic       load_reg_a, load_reg_b, load_reg_c;
   logic       busy, halted, illegal_op;
   state_t     dbg_state;

   cpu_sequencer #(.ADDR_W(4)) dut (
      .clk(clk), .rst(rst), .start(start),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_data(imem_data),
      .operand(operand),
      .load_reg_a(load_reg_a), .load_reg_b(load_reg_b), .load_reg_c(load_reg_c),
      .busy(busy), .halted(halted), .illegal_op(illegal_op),
      .dbg_state(dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [7:0] mem [16];
   bit         mem_on      = 1'b1;
   int         wait_target = 0;
   int         wait_cnt    = 0;

   int         cyc;
   int         a_q[$], b_q[$], c_q[$], ill_q[$];
   logic [3:0] a_op[$], b_op[$];
   int         fetch_q[$];
   int         halt_cyc;
   int         onehot_err, addr_err, addr1_req;
   logic       prev_req;
   logic [3:0] prev_addr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      cyc = 0;
      a_q.delete(); b_q.delete(); c_q.delete(); ill_q.delete();
      a_op.delete(); b_op.delete(); fetch_q.delete();
      halt_cyc = -1; onehot_err = 0; addr_err = 0; addr1_req = 0;
      prev_req = 1'b0; prev_addr = '0; wait_cnt = 0;
   endtask

   // One clock: sample/record outputs #1 after the edge, then answer the fetch.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (load_reg_a) begin a_q.push_back(cyc); a_op.push_back(operand); end
      if (load_reg_b) begin b_q.push_back(cyc); b_op.push_back(operand); end
      if (load_reg_c) c_q.push_back(cyc);
      if (illegal_op) ill_q.push_back(cyc);
      if (halted && halt_cyc < 0) halt_cyc = cyc;
      if ((int'(load_reg_a) + int'(load_reg_b) + int'(load_reg_c)) > 1) onehot_err++;
      if ((load_reg_a || load_reg_b || load_reg_c) && dbg_state != EXEC) onehot_err++;
      if (imem_req && prev_req && imem_addr != prev_addr) addr_err++;
      if (imem_req && imem_addr == 4'd1) addr1_req++;
      prev_req  = imem_req;
      prev_addr = imem_addr;
      if (mem_on) begin
         if (imem_req) begin
            if (wait_cnt == wait_target) begin
               imem_ack  = 1'b1;
               imem_data = mem[imem_addr];
               fetch_q.push_back(int'(imem_addr));
               wait_cnt  = 0;
            end else begin
               imem_ack = 1'b0;
               wait_cnt++;
            end
         end else begin
            imem_ack = 1'b0;
            wait_cnt = 0;
         end
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      imem_ack = 1'b0;
      start = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic launch();
      clear_log();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic load_prog(input logic [7:0] fill);
      for (int i = 0; i < 16; i++) mem[i] = fill;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; imem_ack = 1'b0; imem_data = 8'h00;
      load_prog(8'h00);
      clear_log();

      // Reset state
      do_reset();
      chk("rst_state", 32'(dbg_state), 32'(IDLE));
      chk("rst_outs", {imem_req, load_reg_a, load_reg_b, load_reg_c, illegal_op, busy, halted}, 7'b0);
      chk("rst_addr_opd", {imem_addr, operand}, 8'h00);

      // Zero-wait program: LOADA 5, LOADB 7, READOUT, HALT
      load_prog(8'hF0);
      mem[0] = 8'h15; mem[1] = 8'h27; mem[2] = 8'h30; mem[3] = 8'hF0;
      wait_target = 0;
      launch();
      chk("t1_fetch_busy", {imem_req, busy, imem_addr}, {1'b1, 1'b1, 4'd0});
      run(12);
      chk("t1_a_cyc", a_q.size() == 1 ? a_q[0] : -1, 3);
      chk("t1_a_opd", 32'(a_op.size() == 1 ? a_op[0] : 4'hx), 5);
      chk("t1_b_cyc", b_q.size() == 1 ? b_q[0] : -1, 6);
      chk("t1_b_opd", 32'(b_op.size() == 1 ? b_op[0] : 4'hx), 7);
      chk("t1_c_cyc", c_q.size() == 1 ? c_q[0] : -1, 9);
      chk("t1_halt_cyc", halt_cyc, 13);
      chk("t1_halt_outs", {halted, busy, imem_req}, 3'b100);
      chk("t1_onehot", onehot_err, 0);
      chk("t1_no_ill", ill_q.size(), 0);

      // Two wait states on every fetch
      do_reset();
      wait_target = 2;
      launch();
      run(20);
      chk("t2_a_cyc", a_q.size() == 1 ? a_q[0] : -1, 5);
      chk("t2_b_cyc", b_q.size() == 1 ? b_q[0] : -1, 10);
      chk("t2_c_cyc", c_q.size() == 1 ? c_q[0] : -1, 15);
      chk("t2_halt_cyc", halt_cyc, 21);
      chk("t2_addr_stable", addr_err, 0);
      wait_target = 0;

      // JMP skips address 1
      do_reset();
      load_prog(8'hF0);
      mem[0] = 8'h42; mem[1] = 8'h33; mem[2] = 8'h11; mem[3] = 8'hF0;
      launch();
      run(10);
      chk("t3_fetch_n", fetch_q.size(), 3);
      chk("t3_fetch1", fetch_q.size() > 1 ? fetch_q[1] : -1, 2);
      chk("t3_fetch2", fetch_q.size() > 2 ? fetch_q[2] : -1, 3);
      chk("t3_a_cyc", a_q.size() == 1 ? a_q[0] : -1, 6);
      chk("t3_a_opd", 32'(a_op.size() == 1 ? a_op[0] : 4'hx), 1);
      chk("t3_no_c", c_q.size(), 0);
      chk("t3_addr1", addr1_req, 0);
      chk("t3_halted", halted, 1);

      // PC wrap through 15 -> 0 with all NOPs
      do_reset();
      load_prog(8'h00);
      launch();
      run(52);
      chk("t4_fetch_n", fetch_q.size(), 18);
      chk("t4_wrap14", fetch_q.size() > 14 ? fetch_q[14] : -1, 14);
      chk("t4_wrap15", fetch_q.size() > 15 ? fetch_q[15] : -1, 15);
      chk("t4_wrap0", fetch_q.size() > 16 ? fetch_q[16] : -1, 0);
      chk("t4_wrap1", fetch_q.size() > 17 ? fetch_q[17] : -1, 1);

      // Illegal opcode, then start held high in HALTED restarts only once
      do_reset();
      load_prog(8'hF0);
      mem[0] = 8'h9A; mem[1] = 8'hF0;
      launch();
      run(6);
      chk("t5_ill_n", ill_q.size(), 1);
      chk("t5_ill_cyc", ill_q.size() == 1 ? ill_q[0] : -1, 3);
      chk("t5_no_loads", a_q.size() + b_q.size() + c_q.size(), 0);
      chk("t5_next_addr", fetch_q.size() > 1 ? fetch_q[1] : -1, 1);
      chk("t5_halt_cyc", halt_cyc, 7);
      clear_log();
      start = 1'b1;
      step();
      chk("t5_restart", {busy, halted, imem_req, imem_addr}, {3'b101, 4'd0});
      run(6);
      chk("t5_rehalt", halted, 1);
      run(6);
      chk("t5_no_second_restart", {halted, busy, imem_req}, 3'b100);
      chk("t5_fetch_once", fetch_q.size(), 2);
      start = 1'b0;

      // Asynchronous reset mid-fetch, late ack ignored
      do_reset();
      mem_on = 1'b0;
      imem_ack = 1'b0;
      clear_log();
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk("t6_req_wait", {imem_req, 32'(dbg_state) == 32'(FETCH)}, 2'b11);
      #3 rst = 1'b1;
      #1;
      chk("t6_req_async", imem_req, 0);
      chk("t6_state_async", 32'(dbg_state), 32'(IDLE));
      #1 rst = 1'b0;
      imem_ack = 1'b1;
      imem_data = 8'h15;
      step();
      step();
      imem_ack = 1'b0;
      step();
      chk("t6_late_ack", {a_q.size() + b_q.size() + c_q.size() + ill_q.size()}, 0);
      chk("t6_idle", {32'(dbg_state) == 32'(IDLE), imem_req, busy, operand}, {3'b100, 4'h0});
      mem_on = 1'b1;
      load_prog(8'hF0);
      mem[0] = 8'h15;
      launch();
      run(2);
      chk("t6_refetch0", fetch_q.size() > 0 ? fetch_q[0] : -1, 0);
      chk("t6_a_cyc", a_q.size() == 1 ? a_q[0] : -1, 3);
      chk("t6_a_opd", 32'(a_op.size() == 1 ? a_op[0] : 4'hx), 5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
